video_sig_gen: RTL and testbench

Timing generator for the XGA 1024x768@60 Hz display path, clocked at the 65 MHz pixel clock. It produces the pixel coordinates consumed by the pattern/pong colour mux, plus the sync, active-draw, new-frame and frame-count signals. It sits directly upstream of the colour mux and feeds it hcount_out and vcount_out. Its sync and active-draw outputs go, pipeline-aligned, to the HDMI/VGA output stage.

---
 rtl/video_timing_pkg.sv | 29 ++
 rtl/video_sig_gen.sv | 123 ++++++++++++
 tb/tb_video_sig_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - XGA 1024x768@60 timing constants and count widths
//
// Purpose: shared timing numbers for the signal generator, colour mux and
//          output stage, so every stage agrees on the raster geometry.
// Contents: horizontal/vertical active, porch and sync widths, derived
//           totals, sync polarities, frame-count modulus, counter widths.
package video_timing_pkg;

    localparam int XGA_ACTIVE_H = 1024;
    localparam int XGA_FP_H     = 24;
    localparam int XGA_SYNC_H   = 136;
    localparam int XGA_BP_H     = 160;
    localparam int XGA_TOTAL_H  = XGA_ACTIVE_H + XGA_FP_H + XGA_SYNC_H + XGA_BP_H;

    localparam int XGA_ACTIVE_V = 768;
    localparam int XGA_FP_V     = 3;
    localparam int XGA_SYNC_V   = 6;
    localparam int XGA_BP_V     = 29;
    localparam int XGA_TOTAL_V  = XGA_ACTIVE_V + XGA_FP_V + XGA_SYNC_V + XGA_BP_V;

    localparam bit XGA_HS_POL   = 1'b0;
    localparam bit XGA_VS_POL   = 1'b0;
    localparam int XGA_FPS      = 60;

    localparam int HCOUNT_W     = 11;
    localparam int VCOUNT_W     = 10;
    localparam int FC_W         = 6;

endpackage

// File: rtl/video_sig_gen.sv
// rtl/video_sig_gen.sv - raster timing generator: counters plus sync/active/new-frame decode
//
// Purpose: walks the pixel raster one pixel per clock and decodes the sync,
//          active-draw and new-frame strobes from the same registered
//          coordinate, so all outputs describe one pixel in one cycle.
// Ports:
//   clk_pixel_in  in   pixel clock
//   rst_in        in   synchronous active-high reset
//   hcount_out    out  horizontal pixel index 0..TOTAL_H-1
//   vcount_out    out  vertical line index 0..TOTAL_V-1
//   hs_out        out  horizontal sync, asserted level HS_POL
//   vs_out        out  vertical sync, asserted level VS_POL
//   ad_out        out  active draw (visible pixel)
//   nf_out        out  one-cycle pulse at the first blanking pixel after the last visible line
//   fc_out        out  frame counter 0..FPS-1
module video_sig_gen
    import video_timing_pkg::*;
#(
    parameter int ACTIVE_H = XGA_ACTIVE_H,
    parameter int FP_H     = XGA_FP_H,
    parameter int SYNC_H   = XGA_SYNC_H,
    parameter int BP_H     = XGA_BP_H,
    parameter int ACTIVE_V = XGA_ACTIVE_V,
    parameter int FP_V     = XGA_FP_V,
    parameter int SYNC_V   = XGA_SYNC_V,
    parameter int BP_V     = XGA_BP_V,
    parameter bit HS_POL   = XGA_HS_POL,
    parameter bit VS_POL   = XGA_VS_POL,
    parameter int FPS      = XGA_FPS
) (
    input  logic                clk_pixel_in,
    input  logic                rst_in,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic                ad_out,
    output logic                nf_out,
    output logic [FC_W-1:0]     fc_out
);

    localparam int TOTAL_H = ACTIVE_H + FP_H + SYNC_H + BP_H;
    localparam int TOTAL_V = ACTIVE_V + FP_V + SYNC_V + BP_V;

    if (TOTAL_H > 2048) begin : g_bad_total_h
        $error("video_sig_gen: TOTAL_H exceeds 2048");
    end
    if (TOTAL_V > 1024) begin : g_bad_total_v
        $error("video_sig_gen: TOTAL_V exceeds 1024");
    end
    if (FPS < 1 || FPS > (1 << FC_W)) begin : g_bad_fps
        $error("video_sig_gen: FPS does not fit the frame counter");
    end

    // Compare one bit wider than the counters: a window end may equal TOTAL
    // (2048 / 1024), which does not fit the counter width itself.
    localparam int HX_W = HCOUNT_W + 1;
    localparam int VX_W = VCOUNT_W + 1;

    localparam logic [HX_W-1:0] H_ACTIVE_X = HX_W'(ACTIVE_H);
    localparam logic [HX_W-1:0] H_SYNC_BEG = HX_W'(ACTIVE_H + FP_H);
    localparam logic [HX_W-1:0] H_SYNC_END = HX_W'(ACTIVE_H + FP_H + SYNC_H);
    localparam logic [HX_W-1:0] H_LAST     = HX_W'(TOTAL_H - 1);

    localparam logic [VX_W-1:0] V_ACTIVE_X = VX_W'(ACTIVE_V);
    localparam logic [VX_W-1:0] V_SYNC_BEG = VX_W'(ACTIVE_V + FP_V);
    localparam logic [VX_W-1:0] V_SYNC_END = VX_W'(ACTIVE_V + FP_V + SYNC_V);
    localparam logic [VX_W-1:0] V_LAST     = VX_W'(TOTAL_V - 1);

    localparam logic [FC_W-1:0] FC_LAST    = FC_W'(FPS - 1);

    logic [HCOUNT_W-1:0] r_hcount;
    logic [VCOUNT_W-1:0] r_vcount;
    logic [FC_W-1:0]     r_fc;

    logic [HX_W-1:0] w_hx;
    logic [VX_W-1:0] w_vx;
    logic            w_h_last;
    logic            w_v_last;
    logic            w_nf;
    logic            w_hs_win;
    logic            w_vs_win;
    logic            w_ad;

    assign w_hx     = {1'b0, r_hcount};
    assign w_vx     = {1'b0, r_vcount};
    assign w_h_last = (w_hx == H_LAST);
    assign w_v_last = (w_vx == V_LAST);
    assign w_nf     = (w_hx == H_ACTIVE_X) && (w_vx == V_ACTIVE_X);
    assign w_hs_win = (w_hx >= H_SYNC_BEG) && (w_hx < H_SYNC_END);
    assign w_vs_win = (w_vx >= V_SYNC_BEG) && (w_vx < V_SYNC_END);
    assign w_ad     = (w_hx < H_ACTIVE_X) && (w_vx < V_ACTIVE_X);

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_fc     <= '0;
        end else begin
            if (w_h_last) begin
                r_hcount <= '0;
                r_vcount <= w_v_last ? '0 : r_vcount + 1'b1;
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
            // fc steps on the nf edge, so it is stable for the whole next frame.
            if (w_nf) begin
                r_fc <= (r_fc == FC_LAST) ? '0 : r_fc + 1'b1;
            end
        end
    end

    // Decodes are gated by reset so a mid-frame reset blanks the outputs
    // in the very cycle it is asserted, not one cycle later.
    assign hcount_out = rst_in ? '0 : r_hcount;
    assign vcount_out = rst_in ? '0 : r_vcount;
    assign hs_out     = (!rst_in && w_hs_win) ? HS_POL : ~HS_POL;
    assign vs_out     = (!rst_in && w_vs_win) ? VS_POL : ~VS_POL;
    assign ad_out     = !rst_in && w_ad;
    assign nf_out     = !rst_in && w_nf;
    assign fc_out     = r_fc;

endmodule

// File: tb/tb_video_sig_gen.sv
// tb/tb_video_sig_gen.sv - scoreboard bench for video_sig_gen (reduced raster plus XGA instance)
module tb_video_sig_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Reduced raster: H 16+2+4+3=25 (hs at 18..21), V 8+1+2+2=13 (vs at 9..10),
    // nf at (16,8), 325 cycles per frame, fc modulo 10.
    logic [10:0] s_h;
    logic [9:0]  s_v;
    logic        s_hs, s_vs, s_ad, s_nf;
    logic [5:0]  s_fc;

    video_sig_gen #(
        .ACTIVE_H(16), .FP_H(2), .SYNC_H(4), .BP_H(3),
        .ACTIVE_V(8),  .FP_V(1), .SYNC_V(2), .BP_V(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .FPS(10)
    ) u_small (
        .clk_pixel_in(clk), .rst_in(rst),
        .hcount_out(s_h), .vcount_out(s_v),
        .hs_out(s_hs), .vs_out(s_vs), .ad_out(s_ad), .nf_out(s_nf), .fc_out(s_fc)
    );

    // Full XGA instance, checked over its first lines after release.
    logic [10:0] x_h;
    logic [9:0]  x_v;
    logic        x_hs, x_vs, x_ad, x_nf;
    logic [5:0]  x_fc;

    video_sig_gen u_xga (
        .clk_pixel_in(clk), .rst_in(rst),
        .hcount_out(x_h), .vcount_out(x_v),
        .hs_out(x_hs), .vs_out(x_vs), .ad_out(x_ad), .nf_out(x_nf), .fc_out(x_fc)
    );

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        ad;
        logic        nf;
        logic [5:0]  fc;
        logic        chk_fc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int m_h = 0, m_v = 0, m_fc = 0;

    function automatic exp_t expect_of(int h, int v, int fc, bit r);
        exp_t e;
        e.chk_fc = !r;
        e.fc     = 6'(fc);
        if (r) begin
            e.h = '0; e.v = '0; e.hs = 1'b1; e.vs = 1'b1; e.ad = 1'b0; e.nf = 1'b0;
        end else begin
            e.h  = 11'(h);
            e.v  = 10'(v);
            e.hs = !(h >= 18 && h <= 21);
            e.vs = !(v >= 9 && v <= 10);
            e.ad = (h < 16) && (v < 8);
            e.nf = (h == 16) && (v == 8);
        end
        return e;
    endfunction

    task automatic step(input bit r);
        rst = r;
        sb.push_back(expect_of(m_h, m_v, m_fc, r));
        @(posedge clk);
        if (r) begin
            m_h = 0; m_v = 0; m_fc = 0;
        end else begin
            if (m_h == 16 && m_v == 8) m_fc = (m_fc == 9) ? 0 : m_fc + 1;
            if (m_h == 24) begin
                m_h = 0;
                m_v = (m_v == 12) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    // Monitor state
    int  cyc = 0;
    bit  line_ok = 0;
    int  hs_cnt = 0;
    bit  nf_seen = 0;
    int  nf_gap = 0;
    int  vs_cnt = 0;
    bit  prev_rst = 1;
    int  x_hs_cnt = 0;
    int  x_hs_first = -1;
    int  x_hs_last = -1;
    bit  x_wrap_next = 0;

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cyc++;
            total++;
            if (s_h !== e.h || s_v !== e.v || s_hs !== e.hs || s_vs !== e.vs ||
                s_ad !== e.ad || s_nf !== e.nf || (e.chk_fc && s_fc !== e.fc)) begin
                bad++;
                $display("FAIL sb cyc%0d: got h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d want h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d",
                         cyc, s_h, s_v, s_hs, s_vs, s_ad, s_nf, s_fc,
                         e.h, e.v, e.hs, e.vs, e.ad, e.nf, e.fc);
            end
        end

        if (rst) begin
            line_ok = 0;
            nf_seen = 0;
            total++;
            if (x_h !== 11'd0 || x_v !== 10'd0 || x_hs !== 1'b1 || x_vs !== 1'b1 ||
                x_ad !== 1'b0 || x_nf !== 1'b0) begin
                bad++;
                $display("FAIL xga_reset: got h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b want 0 0 1 1 0 0",
                         x_h, x_v, x_hs, x_vs, x_ad, x_nf);
            end
        end else begin
            // sync never overlaps active video
            total++;
            if (s_ad && (!s_hs || !s_vs)) begin
                bad++;
                $display("FAIL sync_in_active: h=%0d v=%0d hs=%b vs=%b ad=1 want no sync", s_h, s_v, s_hs, s_vs);
            end

            if (s_h == 0) begin
                hs_cnt  = 0;
                line_ok = 1;
            end
            if (!s_hs) hs_cnt++;
            if (s_h == 24 && line_ok) begin
                total++;
                if (hs_cnt != 4) begin
                    bad++;
                    $display("FAIL hs_width: got %0d want 4 (v=%0d)", hs_cnt, s_v);
                end
            end

            nf_gap++;
            if (!s_vs) vs_cnt++;
            if (s_nf) begin
                if (nf_seen) begin
                    total++;
                    if (nf_gap != 325 || vs_cnt != 50) begin
                        bad++;
                        $display("FAIL frame_len: got gap=%0d vs_cycles=%0d want gap=325 vs_cycles=50", nf_gap, vs_cnt);
                    end
                end
                nf_seen = 1;
                nf_gap  = 0;
                vs_cnt  = 0;
            end

            // XGA instance
            if (prev_rst) begin
                total++;
                if (x_h !== 11'd0 || x_v !== 10'd0 || x_ad !== 1'b1 || x_fc !== 6'd0) begin
                    bad++;
                    $display("FAIL xga_release: got h=%0d v=%0d ad=%b fc=%0d want 0 0 1 0", x_h, x_v, x_ad, x_fc);
                end
                x_hs_cnt = 0; x_hs_first = -1; x_hs_last = -1; x_wrap_next = 0;
            end
            if (x_wrap_next) begin
                x_wrap_next = 0;
                total++;
                if (x_h !== 11'd0 || x_v !== 10'd1) begin
                    bad++;
                    $display("FAIL xga_wrap: got h=%0d v=%0d want 0 1", x_h, x_v);
                end
                total++;
                if (x_hs_cnt != 136 || x_hs_first != 1048 || x_hs_last != 1183) begin
                    bad++;
                    $display("FAIL xga_hs: got cnt=%0d first=%0d last=%0d want 136 1048 1183",
                             x_hs_cnt, x_hs_first, x_hs_last);
                end
            end
            if (x_v == 10'd0) begin
                if (!x_hs) begin
                    x_hs_cnt++;
                    if (x_hs_first < 0) x_hs_first = int'(x_h);
                    x_hs_last = int'(x_h);
                end
                if (x_h == 11'd1023 || x_h == 11'd1024) begin
                    total++;
                    if (x_ad !== (x_h == 11'd1023)) begin
                        bad++;
                        $display("FAIL xga_ad_edge: h=%0d got ad=%b want %b", x_h, x_ad, x_h == 11'd1023);
                    end
                end
                if (x_h == 11'd1343) x_wrap_next = 1;
            end
        end
        prev_rst = rst;
    end

    initial begin
        @(posedge clk);
        #1;
        repeat (5) step(1'b1);
        run(11 * 325);          // fc wraps 9 -> 0 on the way, ends at (0,0) fc=1
        run(6 * 325);           // (0,0) fc=7
        run(5 * 25 + 10);       // (10,5) fc=7
        step(1'b1);             // one-cycle mid-frame reset
        run(400);
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
